// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-requester round-robin arbiter and sequencer for a shared
//               single-port synchronous memory. Optional macro
//               MEM_ARB_FIXED_PRIO_EN selects fixed priority (requester 0 wins).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  ack0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_read,
    output logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_ACK     = 2'd3
    } state_t;

    state_t                r_state, w_state_nxt;
    logic                  r_gnt, w_gnt_nxt;
    logic                  r_we, w_we_nxt;
    logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [DATA_WIDTH-1:0] r_mem_data_in, w_mem_data_in_nxt;
    logic                  r_mem_read, w_mem_read_nxt;
    logic                  r_mem_write, w_mem_write_nxt;
    logic                  r_ack0, w_ack0_nxt;
    logic                  r_ack1, w_ack1_nxt;
    logic [DATA_WIDTH-1:0] r_rdata0, w_rdata0_nxt;
    logic [DATA_WIDTH-1:0] r_rdata1, w_rdata1_nxt;
    logic                  r_busy, w_busy_nxt;

    logic                  w_pick1;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign w_pick1 = req1 & ~req0;
`else
    logic r_last_grant, w_last_grant_nxt;
    // On contention the requester that did not win last time is served.
    assign w_pick1 = req1 & (~req0 | ~r_last_grant);
`endif

    assign w_sel_we    = w_pick1 ? we1    : we0;
    assign w_sel_addr  = w_pick1 ? addr1  : addr0;
    assign w_sel_wdata = w_pick1 ? wdata1 : wdata0;

    always_comb begin
        w_state_nxt       = r_state;
        w_gnt_nxt         = r_gnt;
        w_we_nxt          = r_we;
        w_mem_addr_nxt    = r_mem_addr;
        w_mem_data_in_nxt = r_mem_data_in;
        w_rdata0_nxt      = r_rdata0;
        w_rdata1_nxt      = r_rdata1;
        w_mem_read_nxt    = 1'b0;
        w_mem_write_nxt   = 1'b0;
        w_ack0_nxt        = 1'b0;
        w_ack1_nxt        = 1'b0;
        w_busy_nxt        = 1'b1;
`ifndef MEM_ARB_FIXED_PRIO_EN
        w_last_grant_nxt  = r_last_grant;
`endif
        case (r_state)
            S_IDLE: begin
                w_busy_nxt = 1'b0;
                if (req0 || req1) begin
                    w_gnt_nxt         = w_pick1;
                    w_we_nxt          = w_sel_we;
                    w_mem_addr_nxt    = w_sel_addr;
                    w_mem_data_in_nxt = w_sel_wdata;
                    w_mem_write_nxt   = w_sel_we;
                    w_mem_read_nxt    = ~w_sel_we;
                    w_busy_nxt        = 1'b1;
                    w_state_nxt       = S_ISSUE;
`ifndef MEM_ARB_FIXED_PRIO_EN
                    w_last_grant_nxt  = w_pick1;
`endif
                end
            end
            S_ISSUE: begin
                if (r_we) begin
                    w_ack0_nxt  = ~r_gnt;
                    w_ack1_nxt  = r_gnt;
                    w_state_nxt = S_ACK;
                end else begin
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                // Memory data is valid in the cycle after the read strobe.
                if (r_gnt) begin
                    w_rdata1_nxt = mem_data_out;
                end else begin
                    w_rdata0_nxt = mem_data_out;
                end
                w_ack0_nxt  = ~r_gnt;
                w_ack1_nxt  = r_gnt;
                w_state_nxt = S_ACK;
            end
            S_ACK: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_gnt         <= 1'b0;
            r_we          <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_data_in <= '0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_ack0        <= 1'b0;
            r_ack1        <= 1'b0;
            r_rdata0      <= '0;
            r_rdata1      <= '0;
            r_busy        <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            r_last_grant  <= 1'b1;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_gnt         <= w_gnt_nxt;
            r_we          <= w_we_nxt;
            r_mem_addr    <= w_mem_addr_nxt;
            r_mem_data_in <= w_mem_data_in_nxt;
            r_mem_read    <= w_mem_read_nxt;
            r_mem_write   <= w_mem_write_nxt;
            r_ack0        <= w_ack0_nxt;
            r_ack1        <= w_ack1_nxt;
            r_rdata0      <= w_rdata0_nxt;
            r_rdata1      <= w_rdata1_nxt;
            r_busy        <= w_busy_nxt;
`ifndef MEM_ARB_FIXED_PRIO_EN
            r_last_grant  <= w_last_grant_nxt;
`endif
        end
    end

    assign ack0        = r_ack0;
    assign ack1        = r_ack1;
    assign rdata0      = r_rdata0;
    assign rdata1      = r_rdata1;
    assign mem_addr    = r_mem_addr;
    assign mem_data_in = r_mem_data_in;
    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter with a transaction-level
//               timing model and a behavioural memory. Honours
//               MEM_ARB_FIXED_PRIO_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int c_aw = 5;
    localparam int c_dw = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req0, we0, req1, we1;
    logic [c_aw-1:0] addr0, addr1;
    logic [c_dw-1:0] wdata0, wdata1;
    logic            ack0, ack1;
    logic [c_dw-1:0] rdata0, rdata1;
    logic [c_aw-1:0] mem_addr;
    logic [c_dw-1:0] mem_data_in, mem_data_out;
    logic            mem_read, mem_write, busy;

    mem_arbiter #(.ADDR_WIDTH(c_aw), .DATA_WIDTH(c_dw)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_read(mem_read),
        .mem_write(mem_write), .mem_data_out(mem_data_out), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic we; logic [c_aw-1:0] addr; logic [c_dw-1:0] data; } op_t;
    typedef struct { logic id; int cyc; logic [c_dw-1:0] rd; } ack_t;

    op_t  q0[$];
    op_t  q1[$];
    ack_t log_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   raise0 = 0;
    int   raise1 = 0;
    int   wr_cnt = 0;
    int   rd_cnt = 0;

    // model expectations
    logic            exp_ack0 = 0, exp_ack1 = 0, exp_rd = 0, exp_wr = 0, exp_busy = 0;
    logic [c_dw-1:0] exp_rdata0 = 0, exp_rdata1 = 0, exp_din = 0;
    logic [c_aw-1:0] exp_addr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural single-port memory; contents survive reset.
    logic [c_dw-1:0] tb_mem [32];
    initial begin
        mem_data_out = '0;
        for (int i = 0; i < 32; i++) tb_mem[i] = 8'(i * 7 + 3);
        forever begin
            @(posedge clk);
            if (mem_write) tb_mem[mem_addr] = mem_data_in;
            if (mem_read) mem_data_out <= tb_mem[mem_addr];
        end
    end

    // Transaction-level model: a grant at edge k occupies cycles k..ack, idle again after ack.
    initial begin
        logic            sel;
        op_t             op;
        logic [c_dw-1:0] m_mem [32];
        logic            m_last, m_id, m_we;
        logic [c_dw-1:0] m_res;
        int              m_issue, m_ack, m_free;
        m_last = 1'b1; m_id = 1'b0; m_we = 1'b0; m_res = '0;
        m_issue = -10; m_ack = -10; m_free = 0;
        for (int i = 0; i < 32; i++) m_mem[i] = 8'(i * 7 + 3);
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                exp_ack0 = 0; exp_ack1 = 0; exp_rd = 0; exp_wr = 0; exp_busy = 0;
                exp_rdata0 = 0; exp_rdata1 = 0; exp_din = 0; exp_addr = 0;
                m_last = 1'b1; m_issue = -10; m_ack = -10; m_free = cyc;
            end else begin
                cyc++;
                exp_ack0 = 0; exp_ack1 = 0; exp_rd = 0; exp_wr = 0;
                if (cyc == m_ack) begin
                    if (m_id) exp_ack1 = 1; else exp_ack0 = 1;
                    if (!m_we) begin
                        if (m_id) exp_rdata1 = m_res; else exp_rdata0 = m_res;
                    end
                end
                if (cyc - 1 >= m_free && (req0 || req1)) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                    sel = !req0;
`else
                    sel = (req0 && req1) ? !m_last : req1;
`endif
                    op = sel ? {we1, addr1, wdata1} : {we0, addr0, wdata0};
                    m_id = sel; m_we = op.we; m_last = sel;
                    m_issue = cyc;
                    m_ack = cyc + (op.we ? 1 : 2);
                    m_free = m_ack + 1;
                    exp_addr = op.addr; exp_din = op.data;
                    exp_wr = op.we; exp_rd = !op.we;
                    if (op.we) m_mem[op.addr] = op.data;
                    else m_res = m_mem[op.addr];
                end
                exp_busy = (cyc >= m_issue && cyc <= m_ack);
            end
        end
    end

    // Requester drivers: hold until ack, then present the next queued op or drop.
    initial begin
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) req0 = 1'b0;
            else if (req0 && ack0) begin
                q0.delete(0);
                if (q0.size() > 0) begin {we0, addr0, wdata0} = q0[0]; raise0 = cyc; end
                else req0 = 1'b0;
            end else if (!req0 && q0.size() > 0) begin
                {we0, addr0, wdata0} = q0[0]; req0 = 1'b1; raise0 = cyc;
            end
        end
    end

    initial begin
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) req1 = 1'b0;
            else if (req1 && ack1) begin
                q1.delete(0);
                if (q1.size() > 0) begin {we1, addr1, wdata1} = q1[0]; raise1 = cyc; end
                else req1 = 1'b0;
            end else if (!req1 && q1.size() > 0) begin
                {we1, addr1, wdata1} = q1[0]; req1 = 1'b1; raise1 = cyc;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("ack0", ack0, exp_ack0);
            chk("ack1", ack1, exp_ack1);
            chk("rdata0", rdata0, exp_rdata0);
            chk("rdata1", rdata1, exp_rdata1);
            chk("mem_read", mem_read, exp_rd);
            chk("mem_write", mem_write, exp_wr);
            chk("mem_addr", mem_addr, exp_addr);
            chk("mem_data_in", mem_data_in, exp_din);
            chk("busy", busy, exp_busy);
            chk("rd_wr_exclusive", mem_read & mem_write, 0);
            if (mem_write) wr_cnt++;
            if (mem_read) rd_cnt++;
            if (ack0) log_q.push_back('{1'b0, cyc, rdata0});
            if (ack1) log_q.push_back('{1'b1, cyc, rdata1});
        end
    end

    task automatic wait_done(input string name);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, (q0.size() == 0 && q1.size() == 0), 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int   base, wbase, rbase, n;
        int   ord[4];
        logic [c_dw-1:0] sdat[4];
`ifdef MEM_ARB_FIXED_PRIO_EN
        ord = '{0, 0, 1, 1};
`else
        ord = '{0, 1, 0, 1};
`endif
        sdat = '{8'h03, 8'h11, 8'h22, 8'h18};
        rst_n = 1'b0;
        q0.push_back({1'b1, 5'd1, 8'h11}); q0.push_back({1'b1, 5'd1, 8'h11});
        q1.push_back({1'b1, 5'd2, 8'h22}); q1.push_back({1'b1, 5'd2, 8'h22});
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_ack0", ack0, 0);
        chk("reset_mem_addr", mem_addr, 0);
        rst_n = 1'b1;

        // Contention: both writing, grants alternate (or requester 0 first with fixed priority).
        base = log_q.size();
        wait_done("contention_done");
        chk("contention_count", log_q.size() - base, 4);
        for (int i = 0; i < 4; i++)
            if (base + i < log_q.size()) chk("contention_order", log_q[base + i].id, ord[i]);

        // Read both back concurrently.
        q0.push_back({1'b0, 5'd1, 8'h00});
        q1.push_back({1'b0, 5'd2, 8'h00});
        wait_done("readback_both_done");
        chk("readback_rdata0", rdata0, 8'h11);
        chk("readback_rdata1", rdata1, 8'h22);

        // Single write from requester 0.
        base = log_q.size(); wbase = wr_cnt;
        q0.push_back({1'b1, 5'd5, 8'hA5});
        wait_done("write_done");
        chk("write_ack_count", log_q.size() - base, 1);
        if (log_q.size() > base) begin
            chk("write_ack_id", log_q[base].id, 0);
            chk("write_latency", log_q[base].cyc - raise0, 2);
        end
        chk("write_pulses", wr_cnt - wbase, 1);
        chk("write_addr_held", mem_addr, 5);
        chk("write_data_held", mem_data_in, 8'hA5);

        // Read-back from requester 1.
        base = log_q.size(); rbase = rd_cnt;
        q1.push_back({1'b0, 5'd5, 8'h00});
        wait_done("read_done");
        chk("read_ack_count", log_q.size() - base, 1);
        if (log_q.size() > base) begin
            chk("read_ack_id", log_q[base].id, 1);
            chk("read_latency", log_q[base].cyc - raise1, 3);
        end
        chk("read_pulses", rd_cnt - rbase, 1);
        chk("read_rdata1", rdata1, 8'hA5);
        chk("read_rdata0_kept", rdata0, 8'h11);

        // Single streamer: four back-to-back reads.
        base = log_q.size();
        for (int i = 0; i < 4; i++) q1.push_back({1'b0, 5'(i), 8'h00});
        wait_done("stream_done");
        chk("stream_count", log_q.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            if (base + i < log_q.size()) begin
                chk("stream_id", log_q[base + i].id, 1);
                chk("stream_data", log_q[base + i].rd, sdat[i]);
                if (i > 0) chk("stream_interval", log_q[base + i].cyc - log_q[base + i - 1].cyc, 4);
            end
        end

        // Reset in the middle of a read.
        q0.push_back({1'b0, 5'd3, 8'h00});
        n = 0;
        while (mem_read !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("midread_issue_seen", mem_read, 1);
        base = log_q.size();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_mem_read", mem_read, 0);
        chk("midreset_ack0", ack0, 0);
        chk("midreset_ack1", ack1, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_rdata0", rdata0, 0);
        chk("midreset_rdata1", rdata1, 0);
        q0.delete();
        q1.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midreset_no_ack", log_q.size() - base, 0);
        q0.push_back({1'b0, 5'd3, 8'h00});
        wait_done("post_reset_done");
        chk("post_reset_ack_count", log_q.size() - base, 1);
        if (log_q.size() > base) chk("post_reset_latency", log_q[base].cyc - raise0, 3);
        chk("post_reset_rdata0", rdata0, 8'h18);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
